// File: rtl/vga_timing_decoder_if.sv
// Signal bundle between a VGA stream source (master) and vga_timing_decoder (slave).
// With VGA_DECODER_STATS_EN defined it also carries frame_count and err_count.
interface vga_timing_decoder_if;
    logic       pixel_clock_pulse;
    logic       in_Hsync;
    logic       in_Vsync;
    logic [3:0] in_vgaRed;
    logic [3:0] in_vgaGreen;
    logic [3:0] in_vgaBlue;
    logic [3:0] out_vgaRed;
    logic [3:0] out_vgaGreen;
    logic [3:0] out_vgaBlue;
    logic       out_display_on;
    logic [9:0] count_h;
    logic [9:0] count_v;
    logic       frame_start;
    logic       locked;
`ifdef VGA_DECODER_STATS_EN
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    modport master (
        output pixel_clock_pulse, in_Hsync, in_Vsync, in_vgaRed, in_vgaGreen, in_vgaBlue,
        input  out_vgaRed, out_vgaGreen, out_vgaBlue, out_display_on, count_h, count_v,
        input  frame_start, locked, frame_count, err_count
    );
    modport slave (
        input  pixel_clock_pulse, in_Hsync, in_Vsync, in_vgaRed, in_vgaGreen, in_vgaBlue,
        output out_vgaRed, out_vgaGreen, out_vgaBlue, out_display_on, count_h, count_v,
        output frame_start, locked, frame_count, err_count
    );
`else
    modport master (
        output pixel_clock_pulse, in_Hsync, in_Vsync, in_vgaRed, in_vgaGreen, in_vgaBlue,
        input  out_vgaRed, out_vgaGreen, out_vgaBlue, out_display_on, count_h, count_v,
        input  frame_start, locked
    );
    modport slave (
        input  pixel_clock_pulse, in_Hsync, in_Vsync, in_vgaRed, in_vgaGreen, in_vgaBlue,
        output out_vgaRed, out_vgaGreen, out_vgaBlue, out_display_on, count_h, count_v,
        output frame_start, locked
    );
`endif
endinterface

// File: rtl/vga_timing_decoder.sv
// Sink-side VGA timing decoder: recovers pixel coordinates from Hsync/Vsync, checks line/frame
// lengths and locks after LOCK_FRAMES good frames. VGA_DECODER_STATS_EN adds frame/error counters.
//
// state  | meaning
// SEARCH | waiting for a Vsync leading edge to establish frame phase
// TRACK  | counting consecutive good frames toward lock
// LOCKED | timing matches; captured pixels are passed through
module vga_timing_decoder #(
    parameter int H_DISPLAY   = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_DISPLAY   = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_TOTAL     = 525,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    vga_timing_decoder_if.slave bus
);
    localparam logic        POL       = (SYNC_POL != 0);
    localparam logic [9:0]  CNT_MAX   = 10'h3ff;
    localparam logic [9:0]  H_OFF     = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  V_OFF     = 10'(V_SYNC + V_BACK);
    localparam logic [10:0] H_START   = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END     = 11'(H_SYNC + H_BACK + H_DISPLAY);
    localparam logic [10:0] V_START   = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_END     = 11'(V_SYNC + V_BACK + V_DISPLAY);
    localparam logic [10:0] H_TOTAL_L = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_L = 11'(V_TOTAL);
    localparam logic [7:0]  LOCK_N    = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t      state;
    logic        hs_prev, vs_prev;
    logic [9:0]  h_cnt, v_cnt;
    logic [9:0]  h_next, v_next;
    logic [10:0] h_meas, v_meas;
    logic [7:0]  match_cnt;
    logic        line_err;
    logic        h_edge, v_edge, err_now, frame_good, drop_lock, active;

    always_comb begin
        h_edge = bus.pixel_clock_pulse && (bus.in_Hsync == POL) && (hs_prev != POL);
        v_edge = bus.pixel_clock_pulse && (bus.in_Vsync == POL) && (vs_prev != POL);
        h_meas = {1'b0, h_cnt} + 11'd1;
        v_meas = {1'b0, v_cnt} + 11'd1;
        h_next = h_cnt;
        v_next = v_cnt;
        if (bus.pixel_clock_pulse) begin
            if (h_edge)
                h_next = '0;
            else if (h_cnt != CNT_MAX)
                h_next = h_cnt + 10'd1;
            // Vsync wins when both edges land on the same pulse
            if (v_edge)
                v_next = '0;
            else if (h_edge && v_cnt != CNT_MAX)
                v_next = v_cnt + 10'd1;
        end
        err_now    = bus.pixel_clock_pulse &&
                     ((h_edge && h_meas != H_TOTAL_L) || h_next == CNT_MAX || v_next == CNT_MAX);
        frame_good = (v_meas == V_TOTAL_L) && !line_err && !err_now;
        drop_lock  = (state == LOCKED) && (err_now || (v_edge && v_meas != V_TOTAL_L));
        active     = ({1'b0, h_next} >= H_START) && ({1'b0, h_next} < H_END) &&
                     ({1'b0, v_next} >= V_START) && ({1'b0, v_next} < V_END);
    end

    assign bus.locked = (state == LOCKED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= SEARCH;
            hs_prev            <= ~POL;
            vs_prev            <= ~POL;
            h_cnt              <= '0;
            v_cnt              <= '0;
            match_cnt          <= '0;
            line_err           <= 1'b0;
            bus.frame_start    <= 1'b0;
            bus.out_display_on <= 1'b0;
            bus.out_vgaRed     <= '0;
            bus.out_vgaGreen   <= '0;
            bus.out_vgaBlue    <= '0;
            bus.count_h        <= '0;
            bus.count_v        <= '0;
        end else begin
            bus.frame_start <= 1'b0;
            if (bus.pixel_clock_pulse) begin
                hs_prev         <= bus.in_Hsync;
                vs_prev         <= bus.in_Vsync;
                h_cnt           <= h_next;
                v_cnt           <= v_next;
                bus.frame_start <= v_edge;
                if (v_edge)
                    line_err <= 1'b0;
                else if (err_now)
                    line_err <= 1'b1;

                case (state)
                    SEARCH: begin
                        if (v_edge) begin
                            state     <= TRACK;
                            match_cnt <= '0;
                        end
                    end
                    TRACK: begin
                        if (v_edge) begin
                            if (frame_good) begin
                                if (match_cnt + 8'd1 == LOCK_N) begin
                                    state     <= LOCKED;
                                    match_cnt <= '0;
                                end else begin
                                    match_cnt <= match_cnt + 8'd1;
                                end
                            end else begin
                                match_cnt <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (drop_lock)
                            state <= SEARCH;
                    end
                    default: state <= SEARCH;
                endcase

                if (active && state == LOCKED) begin
                    bus.out_display_on <= 1'b1;
                    bus.out_vgaRed     <= bus.in_vgaRed;
                    bus.out_vgaGreen   <= bus.in_vgaGreen;
                    bus.out_vgaBlue    <= bus.in_vgaBlue;
                    bus.count_h        <= h_next - H_OFF;
                    bus.count_v        <= v_next - V_OFF;
                end else begin
                    bus.out_display_on <= 1'b0;
                    bus.out_vgaRed     <= '0;
                    bus.out_vgaGreen   <= '0;
                    bus.out_vgaBlue    <= '0;
                    bus.count_h        <= '0;
                    bus.count_v        <= '0;
                end
            end
        end
    end

`ifdef VGA_DECODER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.frame_count <= '0;
            bus.err_count   <= '0;
        end else begin
            if (v_edge)
                bus.frame_count <= bus.frame_count + 16'd1;
            if (bus.pixel_clock_pulse && drop_lock && bus.err_count != 8'hff)
                bus.err_count <= bus.err_count + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder on a reduced 16x10 mode: frame table plus hand-written
// sync-loss and mid-line reset sequences; a second instance sees inverted syncs with SYNC_POL=1.
module tb_vga_timing_decoder;
    localparam int HD = 8, HS = 2, HB = 2, HT = 16;
    localparam int VD = 4, VS = 1, VB = 2, VT = 10;

    typedef struct {
        int lines;
        int long_line;
        bit lock0;
        int drop_line;
    } frame_vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    int   fs_a = 0;
    int   fs_b = 0;
    frame_vec_t tbl[21];

    always #5 clk = ~clk;

    vga_timing_decoder_if if_a();
    vga_timing_decoder_if if_b();

    vga_timing_decoder #(
        .H_DISPLAY(HD), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_DISPLAY(VD), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .SYNC_POL(0), .LOCK_FRAMES(2)
    ) dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));

    vga_timing_decoder #(
        .H_DISPLAY(HD), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_DISPLAY(VD), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .SYNC_POL(1), .LOCK_FRAMES(2)
    ) dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));

    always @(negedge clk) begin
        if (if_a.frame_start === 1'b1) fs_a++;
        if (if_b.frame_start === 1'b1) fs_b++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // hs/vs are "sync active"; dut_a sees active-low, dut_b active-high
    task automatic send_pixel(input bit hs, input bit vs, input logic [3:0] r, input logic [3:0] g,
                              input logic [3:0] b);
        @(posedge clk); #1;
        if_a.in_Hsync = ~hs;  if_a.in_Vsync = ~vs;
        if_b.in_Hsync = hs;   if_b.in_Vsync = vs;
        if_a.in_vgaRed = r;   if_a.in_vgaGreen = g;  if_a.in_vgaBlue = b;
        if_b.in_vgaRed = r;   if_b.in_vgaGreen = g;  if_b.in_vgaBlue = b;
        if_a.pixel_clock_pulse = 1'b1;
        if_b.pixel_clock_pulse = 1'b1;
        @(posedge clk); #1;
        if_a.pixel_clock_pulse = 1'b0;
        if_b.pixel_clock_pulse = 1'b0;
    endtask

    task automatic send_frame(input int idx, input int lines, input int long_line, input bit lock0,
                              input int drop_line);
        int bad, fa, fb, len;
        bit el, act;
        logic [3:0] er, eg, eb;
        logic [9:0] ech, ecv;
        logic [35:0] got, want;
        bad = 0; fa = fs_a; fb = fs_b;
        for (int y = 0; y < lines; y++) begin
            len = (y == long_line) ? HT + 1 : HT;
            for (int x = 0; x < len; x++) begin
                send_pixel(x < HS, y < VS, 4'(x), 4'(y), 4'hA);
                el  = lock0 && !(drop_line >= 0 && y >= drop_line);
                act = el && x >= HS + HB && x < HS + HB + HD && y >= VS + VB && y < VS + VB + VD;
                er  = act ? 4'(x) : 4'h0;
                eg  = act ? 4'(y) : 4'h0;
                eb  = act ? 4'hA : 4'h0;
                ech = act ? 10'(x - HS - HB) : 10'd0;
                ecv = act ? 10'(y - VS - VB) : 10'd0;
                got  = {if_a.out_display_on, if_a.out_vgaRed, if_a.out_vgaGreen, if_a.out_vgaBlue,
                        if_a.count_h, if_a.count_v, if_a.locked, if_b.locked, if_b.out_display_on};
                want = {act, er, eg, eb, ech, ecv, el, el, act};
                if (got !== want) begin
                    bad++;
                    if (bad == 1)
                        check($sformatf("frame%0d_pixel_x%0d_y%0d", idx, x, y), 64'(got), 64'(want));
                end
                if (lock0 && drop_line < 0 && x == HS + HB && y == VS + VB) begin
                    check($sformatf("frame%0d_first_active_count_h", idx), 64'(if_a.count_h), 64'd0);
                    check($sformatf("frame%0d_first_active_count_v", idx), 64'(if_a.count_v), 64'd0);
                    check($sformatf("frame%0d_first_active_on", idx), 64'(if_a.out_display_on), 64'd1);
                    check($sformatf("frame%0d_first_active_rgb", idx),
                          64'({if_a.out_vgaRed, if_a.out_vgaGreen, if_a.out_vgaBlue}), 64'h43A);
                end
            end
        end
        check($sformatf("frame%0d_bad_pixels", idx), 64'(bad), 64'd0);
        check($sformatf("frame%0d_frame_start_a", idx), 64'(fs_a - fa), 64'd1);
        check($sformatf("frame%0d_frame_start_b", idx), 64'(fs_b - fb), 64'd1);
        check($sformatf("frame%0d_locked_end", idx), 64'(if_a.locked),
              64'(lock0 && drop_line < 0));
    endtask

    initial begin
        int fa;
        tbl = '{
            '{10, -1, 1'b0, -1}, '{10, -1, 1'b0, -1}, '{10, -1, 1'b1, -1},
            '{10,  5, 1'b1,  6}, '{10, -1, 1'b0, -1}, '{10, -1, 1'b0, -1},
            '{10, -1, 1'b1, -1}, '{ 9, -1, 1'b1, -1}, '{10, -1, 1'b0, -1},
            '{10, -1, 1'b0, -1}, '{10, -1, 1'b0, -1}, '{10, -1, 1'b1, -1},
            '{ 9, -1, 1'b1, -1}, '{ 9, -1, 1'b0, -1}, '{ 9, -1, 1'b0, -1},
            '{ 9, -1, 1'b0, -1}, '{ 9, -1, 1'b0, -1}, '{ 9, -1, 1'b0, -1},
            '{10, -1, 1'b0, -1}, '{10, -1, 1'b0, -1}, '{10, -1, 1'b1, -1}
        };

        reset_n = 1'b0;
        if_a.pixel_clock_pulse = 1'b0; if_b.pixel_clock_pulse = 1'b0;
        if_a.in_Hsync = 1'b1; if_a.in_Vsync = 1'b1;
        if_b.in_Hsync = 1'b0; if_b.in_Vsync = 1'b0;
        if_a.in_vgaRed = '0; if_a.in_vgaGreen = '0; if_a.in_vgaBlue = '0;
        if_b.in_vgaRed = '0; if_b.in_vgaGreen = '0; if_b.in_vgaBlue = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_locked", 64'(if_a.locked), 64'd0);
        check("reset_display_on", 64'(if_a.out_display_on), 64'd0);
        check("reset_count_h", 64'(if_a.count_h), 64'd0);
        check("reset_count_v", 64'(if_a.count_v), 64'd0);
        check("reset_frame_start", 64'(if_a.frame_start), 64'd0);
        check("reset_rgb", 64'({if_a.out_vgaRed, if_a.out_vgaGreen, if_a.out_vgaBlue}), 64'd0);
        check("reset_locked_b", 64'(if_b.locked), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            send_frame(i, tbl[i].lines, tbl[i].long_line, tbl[i].lock0, tbl[i].drop_line);
`ifdef VGA_DECODER_STATS_EN
            if (i == 3) check("err_count_after_long_line", 64'(if_a.err_count), 64'd1);
`endif
        end

        // sync loss: 3 good lines, then 1100 pixels with both syncs held inactive
        send_frame(21, 3, -1, 1'b1, -1);
        fa = fs_a;
        for (int k = 0; k < 1100; k++) begin
            send_pixel(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
            if (k == 899) check("gap_still_locked", 64'(if_a.locked), 64'd1);
        end
        check("gap_unlocked", 64'(if_a.locked), 64'd0);
        check("gap_unlocked_b", 64'(if_b.locked), 64'd0);
        check("gap_no_frame_start", 64'(fs_a - fa), 64'd0);
        send_frame(22, 10, -1, 1'b0, -1);
        send_frame(23, 10, -1, 1'b0, -1);
        send_frame(24, 10, -1, 1'b1, -1);

        // asynchronous reset mid-line while locked and in the active area
        send_frame(25, 3, -1, 1'b1, -1);
        for (int x = 0; x < 6; x++) send_pixel(x < HS, 1'b0, 4'(x), 4'h3, 4'hA);
        check("pre_reset_display_on", 64'(if_a.out_display_on), 64'd1);
        check("pre_reset_count_h", 64'(if_a.count_h), 64'd1);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_locked", 64'(if_a.locked), 64'd0);
        check("async_reset_display_on", 64'(if_a.out_display_on), 64'd0);
        check("async_reset_count_h", 64'(if_a.count_h), 64'd0);
        check("async_reset_rgb", 64'({if_a.out_vgaRed, if_a.out_vgaGreen, if_a.out_vgaBlue}), 64'd0);
        check("async_reset_display_on_b", 64'(if_b.out_display_on), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        send_frame(26, 10, -1, 1'b0, -1);
        send_frame(27, 10, -1, 1'b0, -1);
        send_frame(28, 10, -1, 1'b1, -1);
`ifdef VGA_DECODER_STATS_EN
        check("frame_count_after_reset", 64'(if_a.frame_count), 64'd3);
        check("err_count_after_reset", 64'(if_a.err_count), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
